// File: rtl/add_result_buffer_if.sv
// Handshake and status bundle between the 16-bit CLA adder, the result
// buffer and its consumer / sequencer.
//   slave  : the buffer side (add_result_buffer).
//   master : the environment side (adder producer plus consumer).
interface add_result_buffer_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    // Producer side.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] z_in;
    logic              sign_in;
    logic              zero_in;
    logic              carry_in;
    logic              parity_in;
    logic              overflow_in;

    // Consumer side.
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] z_out;
    logic [4:0]        flags_out;

    // Condition evaluation and overflow bookkeeping.
    logic [2:0]        cond_sel;
    logic              cond_true;
    logic              clr_sticky;
    logic              sticky_ovf;
    logic [CNT_W-1:0]  ovf_count;

    modport slave (
        input  in_valid, z_in, sign_in, zero_in, carry_in, parity_in, overflow_in,
        output in_ready,
        output out_valid, z_out, flags_out,
        input  out_ready,
        input  cond_sel, clr_sticky,
        output cond_true, sticky_ovf, ovf_count
    );

    modport master (
        output in_valid, z_in, sign_in, zero_in, carry_in, parity_in, overflow_in,
        input  in_ready,
        input  out_valid, z_out, flags_out,
        output out_ready,
        output cond_sel, clr_sticky,
        input  cond_true, sticky_ovf, ovf_count
    );
endinterface

// File: rtl/add_result_buffer.sv
// Result buffer behind the 16-bit carry-look-ahead adder.
// Two-entry skid buffer (head + tail) with valid/ready handshake, sticky
// overflow flag, saturating overflow counter and a condition-code evaluator
// on the head entry.
// Optional build macro ADD_RESULT_SATURATE_EN: clamps overflowed sums to the
// signed extreme and rebuilds sign/zero/parity for the clamped value.
// Flag vector layout, MSB first: {sign, zero, carry, parity, overflow}.
module add_result_buffer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input logic               clk,
    input logic               rst,
    add_result_buffer_if.slave bus
);

    localparam int FLAG_W = 5;
    localparam int F_SIGN = 4;
    localparam int F_ZERO = 3;
    localparam int F_CARRY = 2;
    localparam int F_PAR  = 1;
    localparam int F_OVF  = 0;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t                state_q, state_d;

    logic [DATA_W-1:0]   head_z_q, head_z_d;
    logic [FLAG_W-1:0]   head_f_q, head_f_d;
    logic [DATA_W-1:0]   tail_z_q, tail_z_d;
    logic [FLAG_W-1:0]   tail_f_q, tail_f_d;

    logic                sticky_q, sticky_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                push;
    logic                pop;
    logic                ovf_push;
    logic [DATA_W-1:0]   in_z;
    logic [FLAG_W-1:0]   in_f;

`ifdef ADD_RESULT_SATURATE_EN
    // Clamp an overflowed sum to the signed extreme the true result lies past:
    // a negative-looking wrap (sign=1) came from pos+pos, so clamp to max
    // positive; a positive-looking wrap came from neg+neg, so clamp to min.
    // Flags are rebuilt for the clamped value; carry and overflow are kept.
    function automatic logic [DATA_W+FLAG_W-1:0] sat_entry(
        input logic [DATA_W-1:0] z,
        input logic [FLAG_W-1:0] f
    );
        logic [DATA_W-1:0] zc;
        logic [FLAG_W-1:0] fc;
        zc = z;
        fc = f;
        if (f[F_OVF]) begin
            zc = f[F_SIGN] ? {1'b0, {(DATA_W-1){1'b1}}} : {1'b1, {(DATA_W-1){1'b0}}};
            fc[F_SIGN] = zc[DATA_W-1];
            fc[F_ZERO] = 1'b0;
            fc[F_PAR]  = ~^zc;
        end
        return {zc, fc};
    endfunction
`endif

    // Handshake decode: both flags come straight from the state register.
    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    assign bus.z_out      = head_z_q;
    assign bus.flags_out  = head_f_q;
    assign bus.sticky_ovf = sticky_q;
    assign bus.ovf_count  = cnt_q;

    // Shape the incoming entry into the form that gets stored.
    always_comb begin
        in_z = bus.z_in;
        in_f = {bus.sign_in, bus.zero_in, bus.carry_in, bus.parity_in, bus.overflow_in};
`ifdef ADD_RESULT_SATURATE_EN
        {in_z, in_f} = sat_entry(bus.z_in, in_f);
`endif
    end

    // Occupancy next-state and head/tail steering.
    always_comb begin
        state_d  = state_q;
        head_z_d = head_z_q;
        head_f_d = head_f_q;
        tail_z_d = tail_z_q;
        tail_f_d = tail_f_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d  = ONE;
                    head_z_d = in_z;
                    head_f_d = in_f;
                end
            end
            ONE: begin
                if (push && pop) begin
                    // Head leaves and the new entry takes its place.
                    head_z_d = in_z;
                    head_f_d = in_f;
                end else if (push) begin
                    state_d  = FULL;
                    tail_z_d = in_z;
                    tail_f_d = in_f;
                end else if (pop) begin
                    // Head keeps the last popped entry on display.
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d  = ONE;
                    head_z_d = tail_z_q;
                    head_f_d = tail_f_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Sticky overflow and saturating event counter; a same-cycle event
    // beats the clear.
    always_comb begin
        ovf_push = push & in_f[F_OVF];
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (bus.clr_sticky) begin
            sticky_d = ovf_push;
            cnt_d    = ovf_push ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (ovf_push) begin
            sticky_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Condition code on the head entry, masked when nothing is valid.
    always_comb begin
        logic c;
        case (bus.cond_sel)
            3'd0:    c = 1'b1;
            3'd1:    c = head_f_q[F_ZERO];
            3'd2:    c = ~head_f_q[F_ZERO];
            3'd3:    c = head_f_q[F_CARRY];
            3'd4:    c = head_f_q[F_SIGN];
            3'd5:    c = head_f_q[F_OVF];
            3'd6:    c = head_f_q[F_PAR];
            3'd7:    c = (head_f_q[F_SIGN] == head_f_q[F_OVF]);
            default: c = 1'b0;
        endcase
        bus.cond_true = bus.out_valid & c;
    end

    // Control state and visible head entry, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            head_z_q <= '0;
            head_f_q <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            head_z_q <= head_z_d;
            head_f_q <= head_f_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    // Tail slot is never observed unless FULL, so it carries no reset.
    always_ff @(posedge clk) begin
        tail_z_q <= tail_z_d;
        tail_f_q <= tail_f_d;
    end

endmodule

// File: tb/tb_add_result_buffer.sv
// Bench for add_result_buffer: directed stimulus feeding a scoreboard queue,
// with a negedge monitor popping and comparing every accepted output.
module tb_add_result_buffer;

    logic clk;
    logic rst;

    add_result_buffer_if #(.DATA_W(16), .CNT_W(8)) bus ();

    add_result_buffer #(.DATA_W(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [20:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected stored form of an accepted entry.
    function automatic logic [20:0] exp_entry(input logic [15:0] z, input logic [4:0] f);
        logic [15:0] ze;
        logic [4:0]  fe;
        ze = z;
        fe = f;
`ifdef ADD_RESULT_SATURATE_EN
        if (f[0]) begin
            ze = f[4] ? 16'h7FFF : 16'h8000;
            fe = {ze[15], 1'b0, f[2], ~^ze, 1'b1};
        end
`endif
        return {ze, fe};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] z, input logic [4:0] f);
        bus.in_valid = 1'b1;
        bus.z_in     = z;
        {bus.sign_in, bus.zero_in, bus.carry_in, bus.parity_in, bus.overflow_in} = f;
    endtask

    // Offer one entry for one edge; records it in the scoreboard if taken.
    task automatic send(input logic [15:0] z, input logic [4:0] f, input bit flow, output bit acc);
        drive(z, f);
        @(negedge clk);
        acc = bus.in_ready;
        if (flow) chk("no_bubble_out_valid", {31'd0, bus.out_valid}, 32'd1);
        if (acc) sb.push_back(exp_entry(z, f));
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.out_valid) break;
        end
        chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
    endtask

    // Monitor: every accepted head entry must match the scoreboard front.
    always @(negedge clk) begin
        logic [20:0] e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: actual=%0h required=none", bus.z_out);
            end else begin
                e = sb.pop_front();
                chk("out_z", {16'd0, bus.z_out}, {16'd0, e[20:5]});
                chk("out_flags", {27'd0, bus.flags_out}, {27'd0, e[4:0]});
            end
        end
    end

    initial begin
        bit acc;
        logic [7:0] ctab;
        logic [15:0] z5;
        logic [4:0]  f5;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.z_in = '0;
        {bus.sign_in, bus.zero_in, bus.carry_in, bus.parity_in, bus.overflow_in} = 5'd0;
        bus.out_ready  = 1'b0;
        bus.cond_sel   = 3'd0;
        bus.clr_sticky = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_z_out", {16'd0, bus.z_out}, 32'd0);
        chk("rst_flags_out", {27'd0, bus.flags_out}, 32'd0);
        chk("rst_cond_true", {31'd0, bus.cond_true}, 32'd0);
        chk("rst_sticky", {31'd0, bus.sticky_ovf}, 32'd0);
        chk("rst_count", {24'd0, bus.ovf_count}, 32'd0);
        rst = 1'b0;
        tick();

        // Single push, out_ready=1: visible for exactly one cycle
        bus.out_ready = 1'b1;
        bus.cond_sel  = 3'd6;
        send(16'h1234, 5'b00010, 1'b0, acc);
        bus.in_valid = 1'b0;
        chk("t1_accept", {31'd0, acc}, 32'd1);
        @(negedge clk);
        chk("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t1_z_out", {16'd0, bus.z_out}, 32'h1234);
        chk("t1_cond_pe", {31'd0, bus.cond_true}, 32'd1);
        @(negedge clk);
        chk("t1_out_valid_gone", {31'd0, bus.out_valid}, 32'd0);
        chk("t1_z_hold", {16'd0, bus.z_out}, 32'h1234);
        chk("t1_cond_empty", {31'd0, bus.cond_true}, 32'd0);
        tick();

        // Backpressure: two pushes fill, third refused
        bus.out_ready = 1'b0;
        send(16'h0001, 5'b00000, 1'b0, acc);
        chk("t2_acc1", {31'd0, acc}, 32'd1);
        send(16'h0002, 5'b00000, 1'b0, acc);
        chk("t2_acc2", {31'd0, acc}, 32'd1);
        drive(16'h0003, 5'b00000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t2_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
            chk("t2_head_hold", {16'd0, bus.z_out}, 32'h0001);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Streaming 0..7, no bubbles, never full
        for (int i = 0; i < 8; i++) begin
            logic [15:0] w;
            w = 16'(i);
            send(w, {1'b0, (w == 16'd0), 1'b0, ~^w, 1'b0}, (i > 0), acc);
            chk("t3_accept", {31'd0, acc}, 32'd1);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t3_last_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t3_in_ready", {31'd0, bus.in_ready}, 32'd1);
        drain();

        // 300 overflow pushes: counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            send(16'(i), 5'b00001, (i > 0), acc);
            if (i == 0) chk("t4_count_first", {24'd0, bus.ovf_count}, 32'd1);
            if (i == 254) chk("t4_count_254", {24'd0, bus.ovf_count}, 32'd255);
        end
        bus.in_valid = 1'b0;
        chk("t4_count_sat", {24'd0, bus.ovf_count}, 32'd255);
        chk("t4_sticky", {31'd0, bus.sticky_ovf}, 32'd1);
        drain();

        // Clear together with an overflow push: set wins, count 1
        bus.clr_sticky = 1'b1;
        send(16'h0055, 5'b00001, 1'b0, acc);
        bus.clr_sticky = 1'b0;
        bus.in_valid   = 1'b0;
        chk("t4_clr_set_sticky", {31'd0, bus.sticky_ovf}, 32'd1);
        chk("t4_clr_set_count", {24'd0, bus.ovf_count}, 32'd1);
        send(16'h0066, 5'b00000, 1'b0, acc);
        bus.in_valid = 1'b0;
        chk("t4_no_ovf_count", {24'd0, bus.ovf_count}, 32'd1);
        bus.clr_sticky = 1'b1;
        tick();
        bus.clr_sticky = 1'b0;
        chk("t4_clr_sticky", {31'd0, bus.sticky_ovf}, 32'd0);
        chk("t4_clr_count", {24'd0, bus.ovf_count}, 32'd0);
        drain();

        // 7FFF+0001 = 8000 with sign=1, overflow=1; walk all condition codes
        bus.out_ready = 1'b0;
`ifdef ADD_RESULT_SATURATE_EN
        z5 = 16'h7FFF; f5 = 5'b00001; ctab = 8'h25;
`else
        z5 = 16'h8000; f5 = 5'b10001; ctab = 8'hB5;
`endif
        send(16'h8000, 5'b10001, 1'b0, acc);
        bus.in_valid = 1'b0;
        chk("t5_count", {24'd0, bus.ovf_count}, 32'd1);
        @(negedge clk);
        chk("t5_z_out", {16'd0, bus.z_out}, {16'd0, z5});
        chk("t5_flags", {27'd0, bus.flags_out}, {27'd0, f5});
        tick();
        for (int s = 0; s < 8; s++) begin
            bus.cond_sel = 3'(s);
            @(negedge clk);
            chk($sformatf("t5_cond_%0d", s), {31'd0, bus.cond_true}, {31'd0, ctab[s]});
            tick();
        end
        bus.out_ready = 1'b1;
        drain();

        // Async reset while FULL
        bus.out_ready = 1'b0;
        send(16'h00A1, 5'b00001, 1'b0, acc);
        send(16'h00A2, 5'b00000, 1'b0, acc);
        chk("t6_full", {31'd0, bus.in_ready}, 32'd0);
        chk("t6_count_pre", {24'd0, bus.ovf_count}, 32'd2);
        drive(16'hBEEF, 5'b00001);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("t6_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t6_rst_count", {24'd0, bus.ovf_count}, 32'd0);
        chk("t6_rst_sticky", {31'd0, bus.sticky_ovf}, 32'd0);
        chk("t6_rst_z", {16'd0, bus.z_out}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("t6_no_capture", {31'd0, bus.out_valid}, 32'd0);

        // Normal operation after reset
        bus.out_ready = 1'b1;
        send(16'h4242, 5'b00100, 1'b0, acc);
        bus.in_valid = 1'b0;
        chk("t6_accept_after", {31'd0, acc}, 32'd1);
        drain();
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_result_buffer.md
Name: add_result_buffer

Overview:
- Downstream stage of the 16-bit carry-look-ahead adder. Registers each sum and its five status flags (sign, zero, carry, parity, overflow) into a 2-entry skid buffer with a valid/ready handshake.
- Keeps a sticky overflow flag and a saturating overflow counter.
- Evaluates a selectable condition code on the head entry, for use by branch/sequencer logic.

Parameters:
- DATA_W, 16: sum width; must match the adder output width.
- CNT_W, 8: width of the overflow event counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  adder result valid.
- in_ready  out  1  buffer can accept this cycle.
- z_in  in  DATA_W  adder sum.
- sign_in  in  1  adder sign flag (sum MSB).
- zero_in  in  1  adder zero flag.
- carry_in  in  1  adder carry-out.
- parity_in  in  1  adder parity flag (1 = even number of ones).
- overflow_in  in  1  adder signed overflow.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- z_out  out  DATA_W  head sum.
- flags_out  out  5  head flags {sign, zero, carry, parity, overflow}, MSB first.
- cond_sel  in  3  condition select.
- cond_true  out  1  selected condition on head entry.
- clr_sticky  in  1  one-cycle clear of the sticky flag and the counter.
- sticky_ovf  out  1  set by any accepted overflow.
- ovf_count  out  CNT_W  accepted overflow events, saturating.

Behaviour:
- Reset (async, rst=1):
  - Occupancy = 0.
  - out_valid=0, in_ready=1, z_out=0, flags_out=0, cond_true=0, sticky_ovf=0, ovf_count=0.
- Push and pop:
  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
  - All state updates on the rising clk edge.
- Occupancy FSM:
  - States are EMPTY (0), ONE (1), FULL (2).
  - EMPTY: push -> ONE.
  - ONE: push & ~pop -> FULL; pop & ~push -> EMPTY; push & pop -> ONE. In the push & pop case, the head becomes the new entry.
  - FULL: pop -> ONE. No push is possible in FULL.
- Handshake outputs:
  - in_ready = (occupancy != FULL). Decoded from the state register only; no combinational path from out_ready.
  - out_valid = (occupancy != EMPTY).
- Latency:
  - An entry pushed at edge N is visible on z_out/flags_out after edge N when the buffer was EMPTY.
  - Order is strictly FIFO.
- Head outputs:
  - z_out/flags_out hold the head entry while out_valid=1 and out_ready=0.
  - When EMPTY they hold the last popped values (0 after reset).
- cond_true (combinational from the head; forced to 0 when out_valid=0):
  - 0 always true.
  - 1 EQ: zero.
  - 2 NE: ~zero.
  - 3 CS: carry.
  - 4 MI: sign.
  - 5 VS: overflow.
  - 6 PE: parity.
  - 7 GE: sign == overflow.
- sticky_ovf:
  - Set on a push whose stored overflow=1.
  - clr_sticky clears it.
  - If a clear and a set occur in the same cycle, the set wins and the result is 1.
- ovf_count:
  - Increments on each push with overflow=1 and saturates at 2^CNT_W-1 (no wrap).
  - clr_sticky zeroes it.
  - If a clear and an increment occur in the same cycle, the result is 1.
- Data path: flags are stored exactly as received; no recomputation unless the optional feature is compiled in.
- Reset mid-transfer: all entries are discarded immediately. An entry offered during reset is not captured.

Optional Feature:
- Macro: ADD_RESULT_SATURATE_EN.
- Defined: on a push with overflow_in=1, the stored sum is clamped:
  - sign_in=1 (positive + positive wrapped negative) -> 16'h7FFF.
  - sign_in=0 (negative + negative wrapped positive) -> 16'h8000.
- Defined: stored flags for a clamped entry:
  - sign = new MSB.
  - zero = 0.
  - parity = ~^(clamped sum).
  - carry and overflow unchanged.
  - Sticky flag and counter behave identically.
- Undefined: sum and flags pass through unmodified; no clamp logic is present.

Test Plan:
- Reset then single push z_in=16'h1234, flags 5'b00010, out_ready=1.
  - out_valid=1 for exactly one cycle after the edge, z_out=16'h1234.
  - cond_sel=6 -> cond_true=1.
- Hold out_ready=0, push 16'h0001 then 16'h0002, then offer 16'h0003.
  - After two pushes in_ready=0 and 16'h0003 is not accepted.
  - With out_ready=1, outputs are 16'h0001, 16'h0002, in order.
- Steady streaming, in_valid=out_ready=1, 8 words 0..7.
  - One word per cycle, no bubbles, in order, occupancy never reaches FULL.
- Push 300 entries with overflow_in=1.
  - ovf_count=255, sticky_ovf=1.
  - Pulse clr_sticky together with an overflow push: sticky_ovf=1, ovf_count=1.
- Push z_in=16'h8000 with sign=1, overflow=1 (7FFF+0001).
  - Macro undefined: z_out=16'h8000, cond_sel=7 -> cond_true=1.
  - Macro defined: z_out=16'h7FFF, flags {0,0,0,0,1}.
- Assert rst mid-stream while FULL.
  - out_valid=0 and in_ready=1 immediately, without waiting for a clk edge; counters 0.
